// File: rtl/bsg_mem_2r1w_wr_ctrl.sv
// bsg_mem_2r1w_wr_ctrl: write-port controller that initialises every entry and then round-robins two writers onto the single write port
module bsg_mem_2r1w_wr_ctrl #(
  parameter int width_p = -1,
  parameter int els_p = -1,
  parameter logic [width_p-1:0] init_val_p = '0,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     w0_v_i,
  input  logic [addr_width_lp-1:0] w0_addr_i,
  input  logic [width_p-1:0]       w0_data_i,
  output logic                     w0_yumi_o,
  input  logic                     w1_v_i,
  input  logic [addr_width_lp-1:0] w1_addr_i,
  input  logic [width_p-1:0]       w1_data_i,
  output logic                     w1_yumi_o,
  output logic                     mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     ready_o
);
  typedef enum logic {INIT, RUN} state_e;
  localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);
  state_e state_q;
  logic [addr_width_lp-1:0] init_cnt_q;
  logic last_gnt_q;
  logic in_init, run, g0, g1;
  // Outputs are forced to the reset-time INIT view while reset is held
  always_comb begin
    in_init = ~reset_n_i | (state_q == INIT);
    run = reset_n_i & (state_q == RUN) & ~clear_i;
    g0 = w0_v_i & (~w1_v_i | last_gnt_q);
    g1 = w1_v_i & (~w0_v_i | ~last_gnt_q);
    w0_yumi_o = run & g0;
    w1_yumi_o = run & g1;
    ready_o = run;
    mem_w_v_o = in_init | w0_yumi_o | w1_yumi_o;
    mem_w_addr_o = in_init ? (reset_n_i ? init_cnt_q : '0) : (w1_yumi_o ? w1_addr_i : w0_addr_i);
    mem_w_data_o = in_init ? init_val_p : (w1_yumi_o ? w1_data_i : w0_data_i);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= INIT;
      init_cnt_q <= '0;
      last_gnt_q <= 1'b1;
    end else if (state_q == INIT) begin
      if (clear_i) init_cnt_q <= '0;
      else if (init_cnt_q == last_lp) begin
        state_q <= RUN;
        init_cnt_q <= '0;
      end else init_cnt_q <= init_cnt_q + 1'b1;
    end else if (clear_i) begin
      state_q <= INIT;
      init_cnt_q <= '0;
    end else if (w0_yumi_o) last_gnt_q <= 1'b0;
    else if (w1_yumi_o) last_gnt_q <= 1'b1;
  end
endmodule

// File: tb/tb_bsg_mem_2r1w_wr_ctrl.sv
// tb_bsg_mem_2r1w_wr_ctrl: directed vector table plus memory-content checks for the write controller
module tb_bsg_mem_2r1w_wr_ctrl;
  localparam int w_lp = 8;
  localparam int els_lp = 5;
  localparam int aw_lp = 3;
  localparam logic [7:0] iv = 8'hA5;
  logic clk = 1'b0;
  logic reset_n, clear, w0_v, w1_v, w0_yumi, w1_yumi, mem_v, ready;
  logic [aw_lp-1:0] w0_addr, w1_addr, mem_addr;
  logic [w_lp-1:0] w0_data, w1_data, mem_data;
  logic [w_lp-1:0] mem [8];
  int nvec = 0, nbad = 0, idx = 0;
  always #5 clk = ~clk;
  bsg_mem_2r1w_wr_ctrl #(.width_p(w_lp), .els_p(els_lp), .init_val_p(iv)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear),
    .w0_v_i(w0_v), .w0_addr_i(w0_addr), .w0_data_i(w0_data), .w0_yumi_o(w0_yumi),
    .w1_v_i(w1_v), .w1_addr_i(w1_addr), .w1_data_i(w1_data), .w1_yumi_o(w1_yumi),
    .mem_w_v_o(mem_v), .mem_w_addr_o(mem_addr), .mem_w_data_o(mem_data), .ready_o(ready)
  );
  always_ff @(posedge clk) if (mem_v) mem[mem_addr] <= mem_data;
  typedef struct {
    logic rst_n, clr, w0v;
    logic [2:0] w0a;
    logic [7:0] w0d;
    logic w1v;
    logic [2:0] w1a;
    logic [7:0] w1d;
    logic ey0, ey1, emv;
    logic [2:0] ea;
    logic [7:0] ed;
    logic erdy;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic a, b, c, input logic [2:0] d, input logic [7:0] e,
                     input logic f, input logic [2:0] g, input logic [7:0] h,
                     input logic i, j, k, input logic [2:0] l, input logic [7:0] m, input logic n);
    vec_t t;
    t = '{a, b, c, d, e, f, g, h, i, j, k, l, m, n};
    vq.push_back(t);
  endtask
  task automatic chk(input string nm, input int v, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, v, act, exp);
    end
  endtask
  task automatic run_to(input int n);
    for (; idx < n; idx++) begin
      @(negedge clk);
      reset_n = vq[idx].rst_n; clear = vq[idx].clr;
      w0_v = vq[idx].w0v; w0_addr = vq[idx].w0a; w0_data = vq[idx].w0d;
      w1_v = vq[idx].w1v; w1_addr = vq[idx].w1a; w1_data = vq[idx].w1d;
      #1;
      chk("w0_yumi", idx, 32'(w0_yumi), 32'(vq[idx].ey0));
      chk("w1_yumi", idx, 32'(w1_yumi), 32'(vq[idx].ey1));
      chk("mem_w_v", idx, 32'(mem_v), 32'(vq[idx].emv));
      chk("ready", idx, 32'(ready), 32'(vq[idx].erdy));
      if (vq[idx].emv) begin
        chk("mem_w_addr", idx, 32'(mem_addr), 32'(vq[idx].ea));
        chk("mem_w_data", idx, 32'(mem_data), 32'(vq[idx].ed));
      end
    end
    @(negedge clk);
  endtask
  task automatic mchk(input int a, input logic [7:0] e);
    chk("mem_entry", a, 32'(mem[a]), 32'(e));
  endtask
  initial begin
    reset_n = 1'b0; clear = 1'b0; w0_v = 1'b0; w1_v = 1'b0;
    w0_addr = '0; w1_addr = '0; w0_data = '0; w1_data = '0;
    // reset, then first sweep (w0 request during INIT must be ignored)
    repeat (2) add(0,0, 0,0,0, 0,0,0, 0,0,1,0,iv,0);
    add(1,0, 1,3,7, 0,0,0, 0,0,1,0,iv,0);
    for (int i = 1; i < els_lp; i++) add(1,0, 0,0,0, 0,0,0, 0,0,1,3'(i),iv,0);
    add(1,0, 0,0,0, 0,0,0, 0,0,0,0,0,1);
    run_to(vq.size());
    for (int a = 0; a < els_lp; a++) mchk(a, iv);
    // continuous contention alternates, starting with w0
    add(1,0, 1,1,8'h11, 1,4,8'h44, 1,0,1,1,8'h11,1);
    add(1,0, 1,1,8'h11, 1,4,8'h44, 0,1,1,4,8'h44,1);
    add(1,0, 1,1,8'h11, 1,4,8'h44, 1,0,1,1,8'h11,1);
    add(1,0, 1,1,8'h11, 1,4,8'h44, 0,1,1,4,8'h44,1);
    // same address: w0 first, loser w1 lands next cycle
    add(1,0, 1,2,1, 1,2,9, 1,0,1,2,1,1);
    add(1,0, 0,0,0, 1,2,9, 0,1,1,2,9,1);
    add(1,0, 1,3,7, 0,0,0, 1,0,1,3,7,1);
    add(1,0, 0,0,0, 0,0,0, 0,0,0,0,0,1);
    run_to(vq.size());
    mchk(0, iv); mchk(1, 8'h11); mchk(2, 8'h09); mchk(3, 8'h07); mchk(4, 8'h44);
    // clear in RUN with w1 pending: blocked through the full sweep, then granted
    add(1,1, 0,0,0, 1,4,8'h3C, 0,0,0,0,0,0);
    for (int i = 0; i < els_lp; i++) add(1,0, 0,0,0, 1,4,8'h3C, 0,0,1,3'(i),iv,0);
    add(1,0, 0,0,0, 1,4,8'h3C, 0,1,1,4,8'h3C,1);
    // reset at sweep entry 2, clear in INIT at entry 1, then a fresh tie goes to w0
    add(1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(1,0, 0,0,0, 0,0,0, 0,0,1,0,iv,0);
    add(1,0, 0,0,0, 0,0,0, 0,0,1,1,iv,0);
    add(0,0, 0,0,0, 0,0,0, 0,0,1,0,iv,0);
    add(1,0, 0,0,0, 0,0,0, 0,0,1,0,iv,0);
    add(1,1, 0,0,0, 0,0,0, 0,0,1,1,iv,0);
    for (int i = 0; i < els_lp; i++) add(1,0, 0,0,0, 0,0,0, 0,0,1,3'(i),iv,0);
    add(1,0, 1,0,5, 1,1,6, 1,0,1,0,5,1);
    add(1,0, 0,0,0, 1,1,6, 0,1,1,1,6,1);
    run_to(vq.size());
    mchk(0, 8'h05); mchk(1, 8'h06); mchk(2, iv); mchk(3, iv); mchk(4, iv);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
